// File: rtl/shift_pkg.sv
// Shared constants and requester IDs for the shared-shifter arbiter.
package shift_pkg;

    localparam int SHIFT_DATA_W  = 32;
    localparam int SHIFT_SHAMT_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MUL = 1'b1
    } req_id_e;

endpackage

// File: rtl/Shifter.sv
// 32-bit left barrel shifter: five cascaded stages (SLL1, SLL2, SLL4, SLL8, SLL16), zero fill.
module Shifter (
    input  logic [31:0] dataA,
    input  logic [4:0]  dataB,
    output logic [31:0] dataOut
);

    logic [31:0] stage [0:5];

    assign stage[0] = dataA;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_sll
            assign stage[gi+1] = dataB[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
        end
    endgenerate

    assign dataOut = stage[5];

endmodule

// File: rtl/shift_rr_arb.sv
// Two-way arbiter for the shared shifter. SHIFT_ARB_RR_EN selects round-robin
// (with last_gnt pointer); otherwise requester 0 has fixed priority.
module shift_rr_arb (
`ifdef SHIFT_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

`ifdef SHIFT_ARB_RR_EN
    logic last_gnt_q;
    logic last_gnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                gnt_o = last_gnt_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = valid_i;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_o != 2'b00) begin
            last_gnt_d = gnt_o[1];
        end
    end
`else
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (valid_i[0]) begin
                gnt_o = 2'b01;
            end else if (valid_i[1]) begin
                gnt_o = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Shares one left barrel shifter between two valid/ready requesters through a
// capture stage (S1) and a back-pressurable response register (S2).
// Optional feature macro: SHIFT_ARB_RR_EN (round-robin instead of fixed priority).
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W  = SHIFT_DATA_W,
    parameter int SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_data,
    input  logic               rsp_ready
);

    logic               s1_valid_q, s1_valid_d;
    req_id_e            s1_id_q, s1_id_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
    logic               rsp_valid_q, rsp_valid_d;
    req_id_e            rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               s2_free, s1_adv, s1_free;
    logic [1:0]         gnt;
    logic [DATA_W-1:0]  shift_out;

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s1_adv;

    // Gating with rst_n keeps both ready outputs low while reset is held.
    shift_rr_arb u_arb (
`ifdef SHIFT_ARB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .en_i    (s1_free && rst_n),
        .valid_i ({req1_valid, req0_valid}),
        .gnt_o   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    Shifter u_shifter (
        .dataA   (s1_data_q),
        .dataB   (s1_shamt_q),
        .dataOut (shift_out)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        if (s1_free) begin
            s1_valid_d = gnt[0] || gnt[1];
        end
        if (gnt[0]) begin
            s1_id_d    = REQ_ALU;
            s1_data_d  = req0_data;
            s1_shamt_d = req0_shamt;
        end else if (gnt[1]) begin
            s1_id_d    = REQ_MUL;
            s1_data_d  = req1_data;
            s1_shamt_d = req1_shamt;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (s2_free) begin
            rsp_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            rsp_id_d   = s1_id_q;
            rsp_data_d = shift_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= REQ_ALU;
            s1_data_q   <= '0;
            s1_shamt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ_ALU;
            rsp_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_data_q   <= s1_data_d;
            s1_shamt_q  <= s1_shamt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (default and SHIFT_ARB_RR_EN builds).
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = '0;
    logic [4:0]  req0_shamt = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = '0;
    logic [4:0]  req1_shamt = '0;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b0;

    int assertions = 0;
    int failures   = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        req0_shamt = '0;
        req1_shamt = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        assertions++;
        if ({rsp_valid, rsp_id, rsp_data} !== 34'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%0b id=%0b data=%h, want 0/0/00000000", rsp_valid, rsp_id, rsp_data);
        end
        assertions++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got ready0=%0b ready1=%0b, want 0/0", req0_ready, req1_ready);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        $display("reset: rsp_valid=%0b ready=%0b%0b", rsp_valid, req1_ready, req0_ready);
    endtask

    task automatic test_single_op();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 32'h0000_0001;
        req0_shamt = 5'd4;
        #1;
        assertions++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got ready0=%0b ready1=%0b, want 1/0", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
        assertions++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: got rsp_valid=%0b one edge after accept, want 0", rsp_valid);
        end
        tick();
        assertions++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h0000_0010) begin
            failures++;
            $display("FAIL single_rsp: got valid=%0b id=%0b data=%h, want 1/0/00000010", rsp_valid, rsp_id, rsp_data);
        end
        $display("single op: id=%0b data=%h", rsp_id, rsp_data);
        tick();
    endtask

    task automatic test_tie();
        logic [3:0] exp_g;
        logic [31:0] exp_d;
`ifdef SHIFT_ARB_RR_EN
        exp_g = 4'b1010;
`else
        exp_g = 4'b0000;
`endif
        rsp_ready  = 1'b1;
        req0_data  = 32'h0000_0011;
        req0_shamt = 5'd1;
        req1_data  = 32'h0000_0003;
        req1_shamt = 5'd2;
        for (int c = 0; c < 6; c++) begin
            req0_valid = (c < 4);
            req1_valid = (c < 4);
            #1;
            if (c < 4) begin
                assertions++;
                if (req0_ready !== !exp_g[c] || req1_ready !== exp_g[c]) begin
                    failures++;
                    $display("FAIL tie_grant[%0d]: got ready0=%0b ready1=%0b, want grant %0b", c, req0_ready, req1_ready, exp_g[c]);
                end
            end
            if (c >= 2) begin
                exp_d = exp_g[c-2] ? 32'h0000_000C : 32'h0000_0022;
                assertions++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_g[c-2] || rsp_data !== exp_d) begin
                    failures++;
                    $display("FAIL tie_rsp[%0d]: got valid=%0b id=%0b data=%h, want 1/%0b/%h", c-2, rsp_valid, rsp_id, rsp_data, exp_g[c-2], exp_d);
                end
                $display("tie op %0d: id=%0b data=%h", c-2, rsp_id, rsp_data);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_boundary();
        logic [31:0] din  [3] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'hA5A5_A5A5};
        logic [4:0]  sh   [3] = '{5'd0, 5'd31, 5'd16};
        logic [31:0] dexp [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hA5A5_0000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1;
            req1_data  = din[i];
            req1_shamt = sh[i];
            tick();
            idle_inputs();
            tick();
            assertions++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== dexp[i]) begin
                failures++;
                $display("FAIL boundary[%0d]: got valid=%0b id=%0b data=%h, want 1/1/%h", i, rsp_valid, rsp_id, rsp_data, dexp[i]);
            end
            $display("boundary %h << %0d = %h", din[i], sh[i], rsp_data);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        int k = 0;
        int n = 0;
        bit acc, got;
        logic [31:0] seen;
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req0_valid = 1'b1;
            req0_data  = 32'(k + 1);
            req0_shamt = 5'd1;
            #1;
            assertions++;
            if (req0_ready !== (c < 2) || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got ready0=%0b ready1=%0b, want %0b/0", c, req0_ready, req1_ready, (c < 2));
            end
            if (c >= 2) begin
                assertions++;
                if (rsp_valid !== 1'b1 || rsp_data !== 32'd2) begin
                    failures++;
                    $display("FAIL bp_hold[%0d]: got valid=%0b data=%h, want 1/00000002", c, rsp_valid, rsp_data);
                end
            end
            if (req0_ready) k++;
            tick();
        end
        assertions++;
        if (k != 2) begin
            failures++;
            $display("FAIL bp_accepted: got %0d accepted, want 2", k);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            req0_valid = (k < 4);
            req0_data  = 32'(k + 1);
            #1;
            acc  = req0_ready;
            got  = rsp_valid;
            seen = rsp_data;
            if (got) begin
                assertions++;
                if (seen !== 32'(2 * (n + 1))) begin
                    failures++;
                    $display("FAIL bp_drain[%0d]: got data=%h, want %h", n, seen, 32'(2 * (n + 1)));
                end
                $display("drain %0d: data=%h", n, seen);
                n++;
            end
            if (acc) k++;
            tick();
        end
        idle_inputs();
        assertions++;
        if (n != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d responses, want 4", n);
        end
        tick();
        assertions++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_dup: got rsp_valid=%0b after drain, want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_midflight();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 32'h0000_0007;
        req0_shamt = 5'd3;
        tick();
        tick();
        idle_inputs();
        assertions++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_fill: got rsp_valid=%0b before reset, want 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL mid_async: got valid=%0b data=%h right after reset, want 0/00000000", rsp_valid, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            assertions++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale[%0d]: got rsp_valid=%0b, want 0", c, rsp_valid);
            end
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        assertions++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_tie: got ready0=%0b ready1=%0b, want 1/0", req0_ready, req1_ready);
        end
        $display("reset mid-flight: rsp_valid=%0b first tie ready=%0b%0b", rsp_valid, req1_ready, req0_ready);
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_reset();
        test_tie();
        test_boundary();
        test_back_pressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single 32-bit left barrel shifter (`Shifter`, five cascaded SLL1..SLL16 stages) between two requesters, for example the ALU execute path and the iterative multiply unit. It arbitrates between valid/ready request channels and registers the operands into a capture stage. It drives the shared shifter from that stage and returns results through a registered, back-pressurable response port tagged with the requester ID.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width; must equal the shifter width.
- `SHAMT_W`, 5: shift-amount width; must equal the shifter `dataB` width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_data` in DATA_W: value to shift.
- `req0_shamt` in SHAMT_W: left-shift amount.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req1_valid`, `req1_data`, `req1_shamt`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response register holds a result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out DATA_W: `req_data << req_shamt`, with zero fill.
- `rsp_ready` in 1: consumer takes the response.

## Operation
- Two-stage pipeline.
  - S1 is the capture register: `s1_valid`, `s1_id`, `s1_data`, `s1_shamt`.
  - S2 is the response register: `rsp_valid`, `rsp_id`, `rsp_data`.
- The shifter is instantiated combinationally on the S1 outputs. S2 latches its `dataOut`.
- Advance conditions:
  - `s2_free = !rsp_valid | rsp_ready`.
  - `s1_adv = s1_valid & s2_free`.
  - `s1_free = !s1_valid | s1_adv`.
- Arbitration is combinational and happens only when `s1_free`.
  - A winner is chosen among the valid requesters.
  - `reqN_ready` is high only for the winner.
  - At most one `ready` is high per cycle.
  - `reqN_ready` never depends on the same requester's `valid` beyond winner selection.
- Round-robin state: pointer `last_gnt`. With both requests valid, the requester other than `last_gnt` wins. `last_gnt` updates on every accepted request.
- With a single valid requester, that requester wins, regardless of the pointer.
- Requesters must hold `valid`, `data` and `shamt` stable until `ready`. The block does not check this.
- A shift amount of 0 passes data through unchanged. Shift amounts of 31 are legal; only bit 0 of the input survives, landing in bit 31.

## Timing
- Reset values:
  - `s1_valid=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`.
  - `last_gnt=1`, so requester 0 wins the first tie.
  - `req0_ready` and `req1_ready` are 0 while `rst_n` is low.
- Latency: a request accepted at edge N gives `rsp_valid=1` after edge N+1, provided S2 was free.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Back-pressure:
  - `rsp_ready=0` with `rsp_valid=1` holds S2 stable.
  - S1 may still fill once; after that, both `ready` outputs drop.
- Simultaneous drain and fill: S2 consumed and S1 advancing in the same cycle both happen at one edge. A new request may also be accepted into S1 at that edge.
- Reset mid-operation: S1 and S2 contents are discarded immediately, on assertion rather than at the next edge. No response is emitted for in-flight operations.

## Configuration
- `SHIFT_ARB_RR_EN` defined: round-robin arbitration using `last_gnt`, as above.
- `SHIFT_ARB_RR_EN` not defined: fixed priority, requester 0 always wins a tie. The `last_gnt` register is removed, and requester 1 may starve.

## Structure
- The shared package `shift_pkg` holds:
  - constants `SHIFT_DATA_W=32` and `SHIFT_SHAMT_W=5`;
  - a request-ID enum (`REQ_ALU=0`, `REQ_MUL=1`).
- One natural sub-module is `shift_rr_arb`: the 2-way arbiter plus `last_gnt`, with the `SHIFT_ARB_RR_EN` choice localized inside it.
- The existing `Shifter` is instantiated unchanged.

## Test plan
- Single op: after reset, `req0` data=0x0000_0001, shamt=4, `rsp_ready=1`. Required response: `req0_ready` the same cycle; two edges later `rsp_valid=1`, `rsp_id=0`, `rsp_data=0x0000_0010`.
- Tie, round-robin: both requesters hold valid for 4 ops with `rsp_ready=1`. Required response: grants alternate 0,1,0,1, and `rsp_id` follows 0,1,0,1. Without `SHIFT_ARB_RR_EN`, grants are 0,0,0,0.
- Boundary amounts:
  - 0xFFFF_FFFF shamt 0 -> 0xFFFF_FFFF;
  - 0x8000_0001 shamt 31 -> 0x8000_0000;
  - 0xA5A5_A5A5 shamt 16 -> 0xA5A5_0000.
- Back-pressure: `rsp_ready=0` with a stream of requests. Required response: exactly two ops are accepted, then both `ready` outputs stay 0. `rsp_data` holds the first result. Raising `rsp_ready` drains the results in order with no loss or duplication.
- Reset mid-flight: assert `rst_n=0` with S1 and S2 full. Required response: `rsp_valid` drops asynchronously. After release, no stale response appears and the next tie is granted to requester 0.
